decimator_accum: RTL and testbench

Parametrised, multi-channel successor to the basic decimator, for DSP chains that reduce sample rate.
- Decimates CHANNELS parallel lanes by a run-time factor (1..MAX_FACTOR) in one of two modes: sample-and-drop, or accumulate-and-dump (block sum, CIC order 1).
- All lanes share one phase counter, so outputs stay channel-aligned.
- Sits after the ADC/mixer stage and before filters or packetisers; single clock domain.

---
 rtl/decimator_accum_pkg.sv | 17 +
 rtl/decimator_phase_ctr.sv | 63 ++++++
 rtl/decimator_accum.sv | 82 ++++++++
 tb/tb_decimator_accum.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/decimator_accum_pkg.sv
// Shared definitions for the multi-channel decimator: mode encodings and a
// constant-foldable log2 helper used to size the phase counter.
package decimator_accum_pkg;

  localparam logic MODE_SAMPLE = 1'b0;
  localparam logic MODE_SUM    = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/decimator_phase_ctr.sv
// Run-time-modulus phase counter shared by all lanes; latches factor/mode at group start.
// Zero latency on phase_zero/group_done (combinational on the accepted sample); en=0 freezes all state.
module decimator_phase_ctr
  import decimator_accum_pkg::*;
#(
  parameter int MAX_FACTOR   = 16,
  parameter int FACTOR_WIDTH = $clog2(MAX_FACTOR) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic                    data_in_valid,
  input  logic [FACTOR_WIDTH-1:0] factor,
  input  logic                    mode,
  output logic                    phase_zero,
  output logic                    group_done,
  output logic                    mode_eff
);

  localparam int PW = clog2(MAX_FACTOR);
  localparam logic [FACTOR_WIDTH-1:0] ONE   = FACTOR_WIDTH'(1);
  localparam logic [FACTOR_WIDTH-1:0] MAX_F = FACTOR_WIDTH'(MAX_FACTOR);

  logic [PW-1:0]           phase_q, phase_d, phase_eff;
  logic [FACTOR_WIDTH-1:0] factor_q, factor_d, factor_clamped, factor_eff;
  logic                    mode_q, mode_d;
  logic                    accept, start;

  always_comb begin
    accept = en & data_in_valid;
    // A group starts on the first accepted sample at phase 0, or wherever sync lands.
    start  = accept & (sync | (phase_q == '0));

    if (factor == '0)        factor_clamped = ONE;
    else if (factor > MAX_F) factor_clamped = MAX_F;
    else                     factor_clamped = factor;

    factor_eff = start ? factor_clamped : factor_q;
    phase_eff  = start ? '0 : phase_q;
    mode_eff   = start ? mode : mode_q;
    group_done = accept & (FACTOR_WIDTH'(phase_eff) == factor_eff - ONE);
    phase_zero = start;

    phase_d  = phase_q;
    if (accept) phase_d = group_done ? '0 : phase_eff + PW'(1);
    factor_d = start ? factor_clamped : factor_q;
    mode_d   = start ? mode : mode_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      factor_q <= ONE;
      mode_q   <= MODE_SAMPLE;
    end else begin
      phase_q  <= phase_d;
      factor_q <= factor_d;
      mode_q   <= mode_d;
    end
  end

endmodule

// File: rtl/decimator_accum.sv
// Multi-lane decimator (sample-and-drop or block sum); outputs registered, one cycle after the
// group-completing sample. No backpressure: en=0 stalls every register and suppresses data_valid.
module decimator_accum
  import decimator_accum_pkg::*;
#(
  parameter string ARCHITECTURE = "BEHAVIORAL",
  parameter int    DATA_WIDTH   = 8,
  parameter int    CHANNELS     = 2,
  parameter int    MAX_FACTOR   = 16,
  parameter int    FACTOR_WIDTH = $clog2(MAX_FACTOR) + 1,
  parameter int    OUT_WIDTH    = DATA_WIDTH + $clog2(MAX_FACTOR)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           mode,
  input  logic [FACTOR_WIDTH-1:0]        factor,
  input  logic                           sync,
  input  logic                           data_in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic                           data_valid,
  output logic [CHANNELS*OUT_WIDTH-1:0]  data_out
);

  logic accept, phase_zero, group_done, mode_eff;
  logic data_valid_q;

  assign accept = en & data_in_valid;

  decimator_phase_ctr #(
    .MAX_FACTOR   (MAX_FACTOR),
    .FACTOR_WIDTH (FACTOR_WIDTH)
  ) u_phase_ctr (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .sync          (sync),
    .data_in_valid (data_in_valid),
    .factor        (factor),
    .mode          (mode),
    .phase_zero    (phase_zero),
    .group_done    (group_done),
    .mode_eff      (mode_eff)
  );

  always_ff @(posedge clk) begin
    if (rst) data_valid_q <= 1'b0;
    else     data_valid_q <= group_done;
  end

  assign data_valid = data_valid_q;

  if (ARCHITECTURE == "BEHAVIORAL") begin : g_behavioral
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      logic [OUT_WIDTH-1:0] sample_ext, acc_q, acc_d, out_q, out_d;

      // In sample mode the accumulator simply holds the phase-0 sample for the group.
      always_comb begin
        sample_ext = OUT_WIDTH'(data_in[c*DATA_WIDTH +: DATA_WIDTH]);
        acc_d      = acc_q;
        if (phase_zero)                            acc_d = sample_ext;
        else if (accept && (mode_eff == MODE_SUM)) acc_d = acc_q + sample_ext;
        out_d = group_done ? acc_d : out_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          acc_q <= '0;
          out_q <= '0;
        end else begin
          acc_q <= acc_d;
          out_q <= out_d;
        end
      end

      assign data_out[c*OUT_WIDTH +: OUT_WIDTH] = out_q;
    end
  end else begin : g_unsupported
    assign data_out = '0;
  end

endmodule

// File: tb/tb_decimator_accum.sv
// Scoreboard bench for decimator_accum: a sample-list reference model pushes the expected
// registered output for every cycle; each following negedge pops and compares.
module tb_decimator_accum;

  localparam int DW = 8;
  localparam int CH = 2;
  localparam int MF = 16;
  localparam int FW = 5;
  localparam int OW = 12;

  logic             clk = 1'b0;
  logic             rst, en, mode, sync, data_in_valid;
  logic [FW-1:0]    factor;
  logic [CH*DW-1:0] data_in;
  logic             data_valid;
  logic [CH*OW-1:0] data_out;

  typedef struct packed {
    logic             vld;
    logic [CH*OW-1:0] out;
  } exp_t;

  exp_t             sb_q[$];
  int               checks = 0;
  int               failures = 0;
  int               strobes = 0;
  logic [CH*OW-1:0] last_out = '0;

  int               m_cnt = 0;
  int               m_factor = 1;
  bit               m_mode = 1'b0;
  int               s0[$];
  int               s1[$];
  logic [CH*OW-1:0] m_out = '0;

  always #5 clk = ~clk;

  decimator_accum #(
    .ARCHITECTURE ("BEHAVIORAL"),
    .DATA_WIDTH   (DW),
    .CHANNELS     (CH),
    .MAX_FACTOR   (MF),
    .FACTOR_WIDTH (FW),
    .OUT_WIDTH    (OW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .mode          (mode),
    .factor        (factor),
    .sync          (sync),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_out      (data_out)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare the outputs of the previous edge, then drive and predict this edge.
  task automatic step(input bit r, input bit e, input bit v, input bit s,
                      input int f, input bit m, input int d0, input int d1);
    exp_t x;
    int   sum0, sum1;
    @(negedge clk);
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("data_valid", 64'(data_valid), 64'(x.vld));
      check("data_out", 64'(data_out), 64'(x.out));
      if (data_valid === 1'b1) begin
        strobes++;
        last_out = data_out;
      end
    end
    rst           = r;
    en            = e;
    data_in_valid = v;
    sync          = s;
    factor        = FW'(f);
    mode          = m;
    data_in       = {DW'(d1), DW'(d0)};

    x.vld = 1'b0;
    if (r) begin
      m_cnt = 0;
      m_factor = 1;
      m_mode = 1'b0;
      s0.delete();
      s1.delete();
      m_out = '0;
    end else if (e && v) begin
      if (s || m_cnt == 0) begin
        m_factor = (f == 0) ? 1 : ((f > MF) ? MF : f);
        m_mode   = m;
        m_cnt    = 0;
        s0.delete();
        s1.delete();
      end
      s0.push_back(d0);
      s1.push_back(d1);
      m_cnt++;
      if (m_cnt == m_factor) begin
        if (m_mode) begin
          sum0 = 0;
          sum1 = 0;
          foreach (s0[i]) begin
            sum0 += s0[i];
            sum1 += s1[i];
          end
        end else begin
          sum0 = s0[0];
          sum1 = s1[0];
        end
        m_out = {OW'(sum1), OW'(sum0)};
        x.vld = 1'b1;
        m_cnt = 0;
      end
    end
    x.out = m_out;
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 1, 1, 0, 1, 0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  initial begin
    // Reset held with live random input, then one quiet cycle after release.
    for (int i = 0; i < 3; i++) do_reset();
    idle(2);
    check("reset_strobes", 64'(strobes), 64'd0);

    // Sample-and-drop, factor 4.
    strobes = 0;
    for (int n = 0; n < 12; n++) step(0, 1, 1, 0, 4, 0, n, 255 - n);
    idle(1);
    check("m0_strobes", 64'(strobes), 64'd3);
    check("m0_last", 64'(last_out), 64'(247 * 4096 + 8));

    // Block sum, factor 16: saturating-free full-scale sum, then a ramp.
    strobes = 0;
    for (int n = 0; n < 16; n++) step(0, 1, 1, 0, 16, 1, 255, 255);
    idle(1);
    check("sum_full_strobes", 64'(strobes), 64'd1);
    check("sum_full", 64'(last_out), 64'(4080 * 4096 + 4080));
    for (int n = 1; n <= 16; n++) step(0, 1, 1, 0, 16, 1, n, 0);
    idle(1);
    check("sum_ramp", 64'(last_out), 64'd136);

    // Mid-group reconfiguration only takes effect at the next group.
    do_reset();
    strobes = 0;
    for (int i = 1; i <= 12; i++)
      step(0, 1, 1, 0, (i <= 2) ? 4 : 2, (i <= 2) ? 1'b0 : 1'b1, i, i * 10);
    idle(1);
    check("reconf_strobes", 64'(strobes), 64'd5);
    check("reconf_last", 64'(last_out), 64'(230 * 4096 + 23));

    // Gaps in valid and an en=0 stall mid-group.
    do_reset();
    strobes = 0;
    step(0, 1, 1, 0, 3, 1, 10, 1);
    step(0, 1, 0, 0, 3, 1, 77, 77);
    step(0, 1, 1, 0, 3, 1, 20, 2);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1, 3, 0, 99, 99);
    step(0, 1, 0, 0, 3, 1, 55, 55);
    step(0, 1, 1, 0, 3, 1, 30, 3);
    idle(2);
    check("stall_strobes", 64'(strobes), 64'd1);
    check("stall_sum", 64'(last_out), 64'(6 * 4096 + 60));

    // Sync restarts the group at the 3rd sample.
    do_reset();
    strobes = 0;
    step(0, 1, 1, 0, 4, 0, 5, 105);
    step(0, 1, 1, 0, 4, 0, 6, 106);
    step(0, 1, 1, 1, 4, 0, 7, 107);
    for (int i = 8; i <= 11; i++) step(0, 1, 1, 0, 4, 0, i, i + 100);
    idle(1);
    check("sync_strobes", 64'(strobes), 64'd1);
    check("sync_out", 64'(last_out), 64'(107 * 4096 + 7));

    // Clamping: factor 0 acts as 1 (sync included), factor 20 acts as 16; reset drops a partial group.
    do_reset();
    strobes = 0;
    for (int i = 1; i <= 5; i++) step(0, 1, 1, (i == 3), 0, 1, i, 200 + i);
    check("f0_strobes", 64'(strobes), 64'd4);
    for (int i = 0; i < 16; i++) step(0, 1, 1, 0, 20, 1, 1, 2);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 20, 1, 9, 9);
    do_reset();
    idle(2);
    check("clamp_strobes", 64'(strobes), 64'd6);
    check("clamp_out", 64'(last_out), 64'(32 * 4096 + 16));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
